// File: rtl/fetch_queue.sv
// Fetch stage: issues word fetches over a req/drdy handshake and buffers {pc, instr} in a DEPTH-entry FIFO for decode.
// Optional macro FETCH_QUEUE_PERF_EN adds perf_fetched, perf_stall_full and perf_discard counters.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_drdy,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall_full,
  output logic [31:0]     perf_discard
`endif
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d, count_after_push;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic            push, pop;

  assign imem_req         = (state_q != IDLE);
  assign imem_addr        = addr_q;
  assign dec_valid        = (count_q != '0);
  assign dec_instr        = dec_valid ? mem_instr[rd_ptr] : '0;
  assign dec_pc           = dec_valid ? mem_pc[rd_ptr] : '0;
  assign pop              = dec_valid && dec_ready && !redirect_valid;
  assign count_after_push = count_q + CW'(1) - CW'(pop);

  // A request is only kept outstanding while a free slot is guaranteed for its response.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          state_d    = REQ;
          fetch_pc_d = redirect_pc;
          addr_d     = redirect_pc;
        end else if (count_q < DEPTH_C) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          if (imem_drdy) addr_d = redirect_pc;
          else           state_d = DISCARD;
        end else if (imem_drdy) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + STEP;
          if (count_after_push < DEPTH_C) addr_d = fetch_pc_q + STEP;
          else                            state_d = IDLE;
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (imem_drdy) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    if (redirect_valid) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      if (redirect_valid) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= fetch_pc_q;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Any response that arrives without being pushed was dropped by a redirect.
  logic drop;
  assign drop = imem_req && imem_drdy && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched    <= '0;
      perf_stall_full <= '0;
      perf_discard    <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (state_q == IDLE && count_q == DEPTH_C) perf_stall_full <= perf_stall_full + 32'd1;
      if (drop) perf_discard <= perf_discard + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic checked by a queue-based scoreboard.
// Build with FETCH_QUEUE_PERF_EN defined to also check the performance counters.
module tb_fetch_queue;
  localparam int              XLEN     = 32;
  localparam int              DEPTH    = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic            clk, rst, redirect_valid, imem_req, imem_drdy, dec_valid, dec_ready;
  logic [XLEN-1:0] redirect_pc, imem_addr, imem_rdata, dec_instr, dec_pc;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]     perf_fetched, perf_stall_full, perf_discard;
`endif

  entry_t          exp_q[$];
  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] stall_addr;
  bit              stale, mon_en;
  int              accepted, discards, total_accepted, checks, errors, mem_mode;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_drdy(imem_drdy), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall_full(perf_stall_full), .perf_discard(perf_discard)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic [XLEN-1:0] rpc, input logic rdy);
    @(posedge clk); #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = rdy;
  endtask

  task automatic doReset(input logic rdy);
    applyStimulus(1'b1, 1'b0, '0, rdy);
    applyStimulus(1'b1, 1'b0, '0, rdy);
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_req", imem_req, 0);
    checkOutput("reset_valid", dec_valid, 0);
    checkOutput("reset_instr", dec_instr, 0);
    checkOutput("reset_pc", dec_pc, 0);
    applyStimulus(1'b0, 1'b0, '0, rdy);
  endtask

  task automatic waitAddr(input logic [XLEN-1:0] a, input int budget, input string name);
    int i = 0;
    @(negedge clk);
    while (!(imem_req === 1'b1 && imem_addr === a) && i < budget) begin
      @(negedge clk);
      i++;
    end
    checkOutput(name, imem_addr, a);
    checkOutput({name, "_req"}, imem_req, 1);
  endtask

  // Memory responder: mode 0 zero-wait, mode 1 random latency, mode 2 zero-wait except stall_addr.
  initial begin
    imem_drdy  = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      case (mem_mode)
        0:       imem_drdy = imem_req;
        1:       imem_drdy = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1);
        default: imem_drdy = imem_req && (imem_addr != stall_addr);
      endcase
      imem_rdata = $urandom;
    end
  end

  // Reference model: the expected fetch stream as a queue of {pc, word}; a response is dropped once after
  // a redirect that caught a request still waiting for memory.
  initial begin
    logic            s_rst, s_rv, s_req, s_drdy;
    logic [XLEN-1:0] s_rpc, s_addr, s_data;
    forever begin
      @(negedge clk);
      s_rst  = rst;
      s_rv   = redirect_valid;
      s_rpc  = redirect_pc;
      s_req  = imem_req;
      s_drdy = imem_drdy;
      s_addr = imem_addr;
      s_data = imem_rdata;
      @(posedge clk);
      if (s_rst !== 1'b0) begin
        exp_q.delete();
        exp_pc   = RESET_PC;
        stale    = 1'b0;
        accepted = 0;
        discards = 0;
      end else if (s_rv) begin
        exp_q.delete();
        if (s_req && s_drdy) discards++;
        stale  = stale || (s_req && !s_drdy);
        exp_pc = s_rpc;
      end else if (s_req && s_drdy) begin
        if (stale) begin
          stale = 1'b0;
          discards++;
        end else begin
          checkOutput("fetch_addr", s_addr, exp_pc);
          checkOutput("fifo_overflow", exp_q.size() >= DEPTH, 0);
          exp_q.push_back('{pc: exp_pc, instr: s_data});
          exp_pc = exp_pc + 1;
          accepted++;
          total_accepted++;
        end
      end
    end
  end

  // Monitor: compares the decode port against the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checkOutput("dec_valid", dec_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          checkOutput("dec_pc", dec_pc, exp_q[0].pc);
          checkOutput("dec_instr", dec_instr, exp_q[0].instr);
          if (dec_ready && !redirect_valid && !rst) void'(exp_q.pop_front());
        end else begin
          checkOutput("dec_pc_empty", dec_pc, 0);
          checkOutput("dec_instr_empty", dec_instr, 0);
        end
      end
    end
  end

  initial begin
    int i;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    mem_mode = 0; stall_addr = 32'hFFFF_FFF0; mon_en = 1'b0;
    checks = 0; errors = 0; accepted = 0; discards = 0; total_accepted = 0;
    exp_pc = RESET_PC; stale = 1'b0;

    $display("[TB] streaming with zero-wait memory");
    doReset(1'b1);
    @(negedge clk);
    checkOutput("first_req_early", imem_req, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput("stream_req", imem_req, 1);
      checkOutput("stream_addr", imem_addr, 32'(k - 1));
      if (k >= 2) checkOutput("stream_valid", dec_valid, 1);
    end

    $display("[TB] decode stalled until the queue fills");
    doReset(1'b0);
    repeat (12) @(negedge clk);
    checkOutput("full_req", imem_req, 0);
    checkOutput("full_valid", dec_valid, 1);
    checkOutput("full_head_pc", dec_pc, 0);
    checkOutput("full_pushes", accepted, 4);
`ifdef FETCH_QUEUE_PERF_EN
    checkOutput("perf_stall_full_nonzero", perf_stall_full != 0, 1);
`endif
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    waitAddr(32'd4, 10, "resume_addr");

    $display("[TB] redirect while a request waits");
    mem_mode = 2; stall_addr = 32'd2;
    doReset(1'b1);
    waitAddr(32'd2, 20, "stall_addr");
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("discard_req", imem_req, 1);
    checkOutput("discard_addr", imem_addr, 2);
    checkOutput("discard_valid", dec_valid, 0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    stall_addr = 32'hFFFF_FFF0;
    waitAddr(32'h100, 10, "redirect_addr");
    i = 0;
    while (dec_valid !== 1'b1 && i < 10) begin
      @(negedge clk);
      i++;
    end
    checkOutput("redirect_first_pc", dec_pc, 32'h100);
`ifdef FETCH_QUEUE_PERF_EN
    checkOutput("perf_discard_one", perf_discard, 1);
`endif

    $display("[TB] redirect coinciding with drdy and pop");
    mem_mode = 0;
    doReset(1'b1);
    repeat (4) @(negedge clk);
    checkOutput("pre_redirect_valid", dec_valid, 1);
    checkOutput("pre_redirect_req", imem_req, 1);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("post_redirect_valid", dec_valid, 0);
    checkOutput("post_redirect_req", imem_req, 1);
    checkOutput("post_redirect_addr", imem_addr, 32'h40);

    $display("[TB] fetch pc wrap");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_top_addr", imem_addr, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("wrap_zero_addr", imem_addr, 32'h0);
    checkOutput("wrap_zero_req", imem_req, 1);

    $display("[TB] reset mid-request with entries buffered");
    mem_mode = 2; stall_addr = 32'd2;
    doReset(1'b0);
    waitAddr(32'd2, 20, "hold_addr");
    checkOutput("hold_valid", dec_valid, 1);
    checkOutput("hold_pc", dec_pc, 0);
    stall_addr = 32'hFFFF_FFF0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("rst_mid_valid", dec_valid, 0);
    checkOutput("rst_mid_req", imem_req, 0);
    @(negedge clk);
    checkOutput("rst_restart_req", imem_req, 1);
    checkOutput("rst_restart_addr", imem_addr, RESET_PC);

    $display("[TB] randomized traffic");
    mem_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      logic            rv, rdy, rr;
      logic [XLEN-1:0] rpc;
      rv  = ($urandom_range(0, 29) == 0);
      rr  = ($urandom_range(0, 799) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : 32'($urandom);
      rdy = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      applyStimulus(rr, rv, rpc, rdy);
    end
    mem_mode = 0;
    repeat (20) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
`ifdef FETCH_QUEUE_PERF_EN
    checkOutput("perf_fetched", perf_fetched, accepted);
    checkOutput("perf_discard", perf_discard, discards);
`endif
    checkOutput("progress", total_accepted > 300, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
